// File: rtl/audio_pkg.sv
// audio_pkg -- shared types and helpers for the audio DAC transmit path.
//
// Contents:
//   SAMPLE_W     width of one PCM sample (16)
//   sample_t     signed 16-bit PCM sample
//   slot_e       channel slot within a frame (LEFT, RIGHT)
//   lrck_level() AUD_DACLRCK level that marks a given slot
//
// Build option: I2S_DELAY_EN selects I2S framing (LRCK low for left,
// data one bit late); undefined gives left-justified framing.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } slot_e;

  // Word-select polarity is the one thing that flips between the two
  // framing formats, so it lives here rather than in the serializer.
  function automatic logic lrck_level(input slot_e slot);
`ifdef I2S_DELAY_EN
    return (slot == RIGHT);
`else
    return (slot == LEFT);
`endif
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// bclk_gen -- bit-clock divider for the audio DAC serializer.
//
// AUD_BCLK toggles every BCLK_HALF cycles of CLOCK_50. The strobes are
// asserted during the CLOCK_50 cycle whose closing edge performs the
// transition, so logic clocked on that edge changes together with AUD_BCLK.
//
// Ports:
//   CLOCK_50   system clock, rising edge
//   reset_n    synchronous active-low reset
//   AUD_BCLK   bit clock (reset value 0)
//   bclk_fall  one-cycle strobe: AUD_BCLK goes 1->0 at the next edge
//   bclk_rise  one-cycle strobe: AUD_BCLK goes 0->1 at the next edge
module bclk_gen #(
  parameter int BCLK_HALF = 8
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  output logic AUD_BCLK,
  output logic bclk_fall,
  output logic bclk_rise
);

  localparam int CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_HALF - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             bclk_reg;
  logic             half_done;

  assign half_done = (cnt_reg == CNT_LAST);
  assign bclk_fall = half_done && bclk_reg;
  assign bclk_rise = half_done && !bclk_reg;
  assign AUD_BCLK  = bclk_reg;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cnt_reg  <= '0;
      bclk_reg <= 1'b0;
    end else if (half_done) begin
      cnt_reg  <= '0;
      bclk_reg <= !bclk_reg;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx -- stereo PCM serializer for an audio codec DAC port.
//
// A one-deep holding register accepts a left/right sample pair with a
// valid/ready handshake. At the start of every frame the pair is copied
// into two shift registers and sent MSB first, left slot then right slot,
// each slot SLOT_BITS bit periods long (bits past the 16th are zero).
// If no new pair arrived, the previous pair is sent again and the sticky
// underrun flag is raised.
//
// Build option: I2S_DELAY_EN -> I2S framing (data one bit period after the
// LRCK edge, LRCK low for left, LRCK resets low). Undefined -> left-justified.
//
// Ports:
//   CLOCK_50       system clock, rising edge
//   reset_n        synchronous active-low reset
//   leftSampleIn   left sample (signed 16)
//   rightSampleIn  right sample (signed 16)
//   sampleValid    pair offered
//   sampleReady    holding register empty (registered)
//   AUD_BCLK       codec bit clock
//   AUD_DACLRCK    codec word select
//   AUD_DACDAT     serial data, changes on falling AUD_BCLK
//   frameStart     one-cycle pulse when a pair is loaded for shifting
//   underrun       sticky: a frame started with an empty holding register
module audio_dac_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic    CLOCK_50,
  input  logic    reset_n,
  input  sample_t leftSampleIn,
  input  sample_t rightSampleIn,
  input  logic    sampleValid,
  output logic    sampleReady,
  output logic    AUD_BCLK,
  output logic    AUD_DACLRCK,
  output logic    AUD_DACDAT,
  output logic    frameStart,
  output logic    underrun
);

  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  logic bclk_fall;
  // Data only moves on falling edges, so the rise strobe has no user here.
  logic bclk_rise_unused;

  bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk_gen (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .AUD_BCLK (AUD_BCLK),
    .bclk_fall(bclk_fall),
    .bclk_rise(bclk_rise_unused)
  );

  logic [BIT_W-1:0]    bit_cnt_reg;
  logic                running_reg;   // cleared by reset: first fall is a frame start
  sample_t             hold_l_reg;
  sample_t             hold_r_reg;
  logic                full_reg;
  logic                ready_reg;
  logic [SAMPLE_W-1:0] sh_l_reg;
  logic [SAMPLE_W-1:0] sh_r_reg;
  logic                dat_reg;
  logic                lrck_reg;
  logic                fs_reg;
  logic                under_reg;
`ifdef I2S_DELAY_EN
  logic                dly_reg;       // one bit period of data delay
`endif

  logic             frame_wrap;
  logic [BIT_W-1:0] bit_cnt_next;
  slot_e            slot_next;
  logic             serial_bit;
  logic             accept;
  logic             full_next;

  always_comb begin
    frame_wrap   = bclk_fall && (!running_reg || (bit_cnt_reg == BIT_LAST));
    bit_cnt_next = frame_wrap ? '0 : bit_cnt_reg + BIT_W'(1);
    slot_next    = (bit_cnt_next < SLOT_LEN) ? LEFT : RIGHT;

    // On the wrap the shift register is being loaded this very edge, so the
    // MSB is taken straight from the holding register.
    if (frame_wrap) begin
      serial_bit = hold_l_reg[SAMPLE_W-1];
    end else if (slot_next == LEFT) begin
      serial_bit = sh_l_reg[SAMPLE_W-1];
    end else begin
      serial_bit = sh_r_reg[SAMPLE_W-1];
    end

    // Load empties the holding register before a same-cycle accept refills it.
    accept    = sampleValid && ready_reg;
    full_next = full_reg;
    if (frame_wrap) begin
      full_next = 1'b0;
    end
    if (accept) begin
      full_next = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      bit_cnt_reg <= '0;
      running_reg <= 1'b0;
      hold_l_reg  <= '0;
      hold_r_reg  <= '0;
      full_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      sh_l_reg    <= '0;
      sh_r_reg    <= '0;
      dat_reg     <= 1'b0;
      lrck_reg    <= lrck_level(LEFT);
      fs_reg      <= 1'b0;
      under_reg   <= 1'b0;
`ifdef I2S_DELAY_EN
      dly_reg     <= 1'b0;
`endif
    end else begin
      fs_reg    <= frame_wrap;
      full_reg  <= full_next;
      ready_reg <= !full_next;

      // The holding register is never cleared on load, so an underrun
      // frame naturally reloads the pair that was sent last.
      if (accept) begin
        hold_l_reg <= leftSampleIn;
        hold_r_reg <= rightSampleIn;
      end

      if (frame_wrap && !full_reg) begin
        under_reg <= 1'b1;
      end

      if (bclk_fall) begin
        bit_cnt_reg <= bit_cnt_next;
        running_reg <= 1'b1;
        lrck_reg    <= lrck_level(slot_next);

        // Zero fill on each shift supplies the padding bits after bit 0.
        if (frame_wrap) begin
          sh_l_reg <= {hold_l_reg[SAMPLE_W-2:0], 1'b0};
          sh_r_reg <= hold_r_reg;
        end else if (slot_next == LEFT) begin
          sh_l_reg <= {sh_l_reg[SAMPLE_W-2:0], 1'b0};
        end else begin
          sh_r_reg <= {sh_r_reg[SAMPLE_W-2:0], 1'b0};
        end

`ifdef I2S_DELAY_EN
        dly_reg <= serial_bit;
        dat_reg <= dly_reg;
`else
        dat_reg <= serial_bit;
`endif
      end
    end
  end

  assign sampleReady = ready_reg;
  assign AUD_DACLRCK = lrck_reg;
  assign AUD_DACDAT  = dat_reg;
  assign frameStart  = fs_reg;
  assign underrun    = under_reg;

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx -- self-checking bench for audio_dac_tx (default parameters).
//
// A reference model derives every expected output from the cycle count
// since reset: bit clock level, frame/bit position, the pair scheduled for
// each frame and the resulting serial bit. Directed scenarios add constant
// checks on whole captured frames, handshake behaviour and reset recovery.
// Builds with or without I2S_DELAY_EN.
module tb_audio_dac_tx;

  localparam int H     = 8;
  localparam int S     = 32;
  localparam int BITS  = 2 * S;
  localparam int FRAME = 2 * H * BITS;
`ifdef I2S_DELAY_EN
  localparam logic LRCK_RST = 1'b0;
`else
  localparam logic LRCK_RST = 1'b1;
`endif

  logic               CLOCK_50 = 1'b0;
  logic               reset_n;
  logic signed [15:0] leftSampleIn;
  logic signed [15:0] rightSampleIn;
  logic               sampleValid;
  logic               sampleReady;
  logic               AUD_BCLK;
  logic               AUD_DACLRCK;
  logic               AUD_DACDAT;
  logic               frameStart;
  logic               underrun;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_dac_tx #(
    .BCLK_HALF(H),
    .SLOT_BITS(S)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .leftSampleIn (leftSampleIn),
    .rightSampleIn(rightSampleIn),
    .sampleValid  (sampleValid),
    .sampleReady  (sampleReady),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .frameStart   (frameStart),
    .underrun     (underrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          n;          // rising edges since reset released
  logic [15:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
  logic        m_full, m_ready, m_under, m_fs, m_dat, m_lrck, m_bclk, m_prev_lj;
  int          m_b;        // bit index set by the latest fall
  int          m_loads;
  logic        m_fall, last_acc;

  // Observations of the DUT.
  logic [63:0] cap, last_cap;
  logic        cap_new;
  logic        prev_bclk, prev_ready;
  int          last_rise_n, last_fs_n, dut_fs_count, ready_rises;

  logic [31:0] pair_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, n);
    end
  endtask

  task automatic step();
    int          j, b, pos, jr;
    logic [15:0] word;
    logic        lj;
    @(posedge CLOCK_50);
    #1;
    last_acc = 1'b0;
    cap_new  = 1'b0;
    m_fall   = 1'b0;
    if (!reset_n) begin
      n = 0;
      m_hold_l = '0; m_hold_r = '0; m_cur_l = '0; m_cur_r = '0;
      m_full = 1'b0; m_ready = 1'b0; m_under = 1'b0; m_fs = 1'b0;
      m_dat = 1'b0; m_lrck = LRCK_RST; m_bclk = 1'b0; m_prev_lj = 1'b0;
      m_b = -1; m_loads = 0; cap = '0;
      last_rise_n = -1; last_fs_n = -1; dut_fs_count = 0; ready_rises = 0;
    end else begin
      n++;
      m_fs   = 1'b0;
      m_bclk = ((n / H) % 2) == 1;
      if (n % (2 * H) == 0) begin
        m_fall = 1'b1;
        j = n / (2 * H);
        b = (j - 1) % BITS;
        m_b = b;
        if (b == 0) begin
          m_fs = 1'b1;
          m_loads++;
          if (m_full) begin
            m_cur_l = m_hold_l;
            m_cur_r = m_hold_r;
            m_full  = 1'b0;
          end else begin
            m_under = 1'b1;
          end
        end
        word = (b < S) ? m_cur_l : m_cur_r;
        pos  = b % S;
        lj   = (pos < 16) ? word[15 - pos] : 1'b0;
`ifdef I2S_DELAY_EN
        m_dat     = m_prev_lj;
        m_prev_lj = lj;
        m_lrck    = !(b < S);
`else
        m_dat  = lj;
        m_lrck = (b < S);
`endif
      end
      if (sampleValid && m_ready) begin
        m_hold_l = leftSampleIn;
        m_hold_r = rightSampleIn;
        m_full   = 1'b1;
        last_acc = 1'b1;
      end
      m_ready = !m_full;
      // Capture the bit the codec samples on each rising bit clock.
      if (n % (2 * H) == H && n > H) begin
        cap = {cap[62:0], AUD_DACDAT};
        jr  = (n - H) / (2 * H);
        if ((jr - 1) % BITS == BITS - 1) begin
          last_cap = cap;
          cap_new  = 1'b1;
        end
      end
    end

    check("bclk",   AUD_BCLK,    m_bclk);
    check("lrck",   AUD_DACLRCK, m_lrck);
    check("dacdat", AUD_DACDAT,  m_dat);
    check("fstart", frameStart,  m_fs);
    check("undrun", underrun,    m_under);
    check("ready",  sampleReady, m_ready);

    if (reset_n) begin
      if (AUD_BCLK && !prev_bclk) begin
        if (last_rise_n >= 0) check("bclk_period", n - last_rise_n, 2 * H);
        last_rise_n = n;
      end
      if (frameStart) begin
        dut_fs_count++;
        if (last_fs_n >= 0) check("frame_len", n - last_fs_n, FRAME);
        last_fs_n = n;
      end
      if (sampleReady && !prev_ready) ready_rises++;
    end
    prev_bclk  = AUD_BCLK;
    prev_ready = sampleReady;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) step();
    check("rst_bclk",  AUD_BCLK,    1'b0);
    check("rst_lrck",  AUD_DACLRCK, LRCK_RST);
    check("rst_dat",   AUD_DACDAT,  1'b0);
    check("rst_fs",    frameStart,  1'b0);
    check("rst_under", underrun,    1'b0);
    check("rst_ready", sampleReady, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    int guard = 0;
    sampleValid   = 1'b1;
    leftSampleIn  = l;
    rightSampleIn = r;
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 4 * FRAME);
    check("offer_accepted", last_acc, 1'b1);
    $display("accept L=%h R=%h at cycle %0d", l, r, n);
    sampleValid = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 100000 && n < target; i++) step();
  endtask

  task automatic run_to_frame_end(input int k);
    run_to(FRAME * (k + 1) + H + 1);
  endtask

  // Stop with the next edge being a frame-load edge.
  task automatic wait_before_load();
    int guard = 0;
    while (!(((n + 1) % (2 * H) == 0) && ((((n + 1) / (2 * H)) - 1) % BITS == 0))
           && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    check("load_edge_found", guard < 2 * FRAME, 1'b1);
  endtask

  function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  initial begin
    int          k;
    int          guard;
    int          lrck_fall_n;
    logic [31:0] p;
    logic        prev_lrck, prev_dat;

    reset_n       = 1'b0;
    sampleValid   = 1'b0;
    leftSampleIn  = '0;
    rightSampleIn = '0;
    prev_bclk     = 1'b0;
    prev_ready    = 1'b0;
    last_cap      = '0;
    n             = 0;

    // Pair accepted before the first frame.
    do_reset(3);
    offer(16'h8001, 16'h7FFE);
    run_to_frame_end(0);
`ifndef I2S_DELAY_EN
    check("A_frame_bits", last_cap, frame_bits(16'h8001, 16'h7FFE));
`endif
    check("A_fs_once", dut_fs_count, 1);
    check("A_no_underrun", underrun, 1'b0);

    // Withheld pair is retransmitted; accept on an empty-holding load edge.
    do_reset(2);
    offer(16'h1234, 16'h5678);
    run_to_frame_end(1);
`ifndef I2S_DELAY_EN
    check("C_retransmit", last_cap, frame_bits(16'h1234, 16'h5678));
`endif
    check("C_underrun_set", underrun, 1'b1);
    wait_before_load();
    offer(16'hABCD, 16'h4321);
    check("C_acc_on_load_fs", frameStart, 1'b1);
    check("C_ready_after_acc", sampleReady, 1'b0);
    run_to_frame_end(2);
`ifndef I2S_DELAY_EN
    check("C_old_pair_sent", last_cap, frame_bits(16'h1234, 16'h5678));
`endif
    run_to_frame_end(3);
`ifndef I2S_DELAY_EN
    check("C_new_pair_kept", last_cap, frame_bits(16'hABCD, 16'h4321));
`endif
    check("C_underrun_sticky", underrun, 1'b1);

    // Continuous random stream: new pair always pending at each load.
    do_reset(1);
    pair_q.delete();
    sampleValid   = 1'b1;
    leftSampleIn  = 16'($urandom_range(0, 65535));
    rightSampleIn = 16'($urandom_range(0, 65535));
    while (n < FRAME * 12 + H + 1) begin
      step();
      if (cap_new && pair_q.size() > 0) begin
        p = pair_q.pop_front();
`ifndef I2S_DELAY_EN
        check("B_frame_bits", last_cap, frame_bits(p[31:16], p[15:0]));
`endif
      end
      if (last_acc) begin
        pair_q.push_back({leftSampleIn, rightSampleIn});
        $display("accept L=%h R=%h at cycle %0d", leftSampleIn, rightSampleIn, n);
        leftSampleIn  = 16'($urandom_range(0, 65535));
        rightSampleIn = 16'($urandom_range(0, 65535));
      end
    end
    sampleValid = 1'b0;
    check("B_no_underrun", underrun, 1'b0);
    check("B_ready_rises", ready_rises, m_loads + 1);
    check("B_fs_count", dut_fs_count, 12);

    // Reset at bit 7 of the left slot, then a clean restart.
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(m_fall && m_b == 7) && guard < 2 * FRAME);
    check("E_bit7_found", m_b, 7);
    repeat (3) step();
    do_reset(1);
    k = 0;
    do begin
      step();
      k++;
      if (k == 1) check("E_ready_after_release", sampleReady, 1'b1);
    end while (!frameStart && k < 8 * H);
    check("E_first_fs_cycle", k, 2 * H);
    check("E_zero_load_underrun", underrun, 1'b1);
    run_to_frame_end(0);
`ifndef I2S_DELAY_EN
    check("E_zero_frame", last_cap, 64'h0);
`endif

`ifdef I2S_DELAY_EN
    // MSB follows the LRCK fall by exactly one bit period.
    do_reset(1);
    sampleValid   = 1'b1;
    leftSampleIn  = 16'h8000;
    rightSampleIn = 16'h0000;
    lrck_fall_n   = -1;
    prev_lrck     = AUD_DACLRCK;
    prev_dat      = AUD_DACDAT;
    guard         = 0;
    while (guard < 3 * FRAME) begin
      step();
      guard++;
      if (lrck_fall_n < 0 && prev_lrck && !AUD_DACLRCK) lrck_fall_n = n;
      if (lrck_fall_n >= 0 && !prev_dat && AUD_DACDAT) break;
      prev_lrck = AUD_DACLRCK;
      prev_dat  = AUD_DACDAT;
    end
    check("I2S_lrck_fall_seen", lrck_fall_n >= 0, 1'b1);
    check("I2S_msb_delay", n - lrck_fall_n, 2 * H);
    sampleValid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
